missile_pool: RTL and testbench

- Parametrised successor to the fixed three-missile invader fire logic.
- Manages NUM_MISSILES invader missile slots:
  - chooses which invader column fires (random or aimed mode);
  - spawns missiles below the lowest live invader in that column;
  - moves missiles down once per frame;
  - retires missiles on a hit or at the screen bottom.
- Sits in the system clock domain between the invader formation logic, the VGA collision outputs and the renderer.

---
 rtl/missile_pool_pkg.sv | 24 ++
 rtl/invader_column_scan.sv | 26 ++
 rtl/missile_pool.sv | 162 ++++++++++++++++
 tb/tb_missile_pool.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/missile_pool_pkg.sv
// Shared constants, FSM encoding and LFSR step for the invader missile pool.
package missile_pool_pkg;

  localparam int INV_COLS      = 11;
  localparam int INV_ROWS      = 5;
  localparam int INV_BITS      = INV_COLS * INV_ROWS;
  localparam int SCREEN_BOTTOM = 470;
  localparam int DEF_COL_PITCH = 16;
  localparam int DEF_ROW_PITCH = 16;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    SPAWN = 2'd2
  } fire_state_e;

  // Fibonacci LFSR, taps 16,14,13,11 (1-based), shifting toward the MSB.
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

endpackage

// File: rtl/invader_column_scan.sv
// Combinational lookup of one formation column: any live invader, and the lowest live row.
module invader_column_scan
  import missile_pool_pkg::*;
(
  input  logic [INV_BITS-1:0] invaders,
  input  logic [3:0]          col,
  output logic                any_alive,
  output logic [2:0]          bottom_row
);

  logic [INV_ROWS-1:0] col_bits;

  always_comb begin
    col_bits = '0;
    for (int c = 0; c < INV_COLS; c++)
      if (col == 4'(c))
        for (int r = 0; r < INV_ROWS; r++)
          col_bits[r] = invaders[r*INV_COLS + c];
    any_alive  = |col_bits;
    // Row 4 is the bottom of the formation, so the highest set row wins.
    bottom_row = '0;
    for (int r = 0; r < INV_ROWS; r++)
      if (col_bits[r]) bottom_row = 3'(r);
  end

endmodule

// File: rtl/missile_pool.sv
// Invader missile pool: picks a firing column, spawns missiles below it,
// moves them down each frame and retires them on hit or at the screen bottom.
module missile_pool
  import missile_pool_pkg::*;
#(
  parameter int NUM_MISSILES  = 3,
  parameter int FIRE_INTERVAL = 40,
  parameter int SPEED         = 2,
  parameter int AIM_MODE      = 0,
  parameter int COL_PITCH     = DEF_COL_PITCH,
  parameter int ROW_PITCH     = DEF_ROW_PITCH,
  parameter int SPRITE_H      = 8,
  parameter int BOTTOM_Y      = SCREEN_BOTTOM
)(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      arst,
  input  logic                      frame,
  input  logic                      done,
  input  logic [INV_BITS-1:0]       invaders,
  input  logic [9:0]                invaders_x,
  input  logic [9:0]                invaders_y,
  input  logic [9:0]                player_x,
  input  logic [NUM_MISSILES-1:0]   missile_collision,
  output logic [NUM_MISSILES-1:0]   m_active,
  output logic [10*NUM_MISSILES-1:0] m_x,
  output logic [10*NUM_MISSILES-1:0] m_y
);

  localparam int CNT_W = (FIRE_INTERVAL > 1) ? $clog2(FIRE_INTERVAL) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(FIRE_INTERVAL - 1);
  localparam logic [3:0] LAST_COL = 4'(INV_COLS - 1);

  logic                    reset;
  logic [15:0]             lfsr;
  logic [CNT_W-1:0]        cnt;
  fire_state_e             state, state_nxt;
  logic [3:0]              col, col_nxt, scanned, scanned_nxt;
  logic [2:0]              row, row_nxt;
  logic                    fire_req, spawn_en;
  logic                    any_alive;
  logic [2:0]              bottom_row;
  logic [NUM_MISSILES-1:0] slot_free, spawn_oh;
  logic [3:0]              lfsr_col, aim_col, start_col;
  logic [9:0]              aim_off, aim_div, spawn_x, spawn_y;

  assign reset    = rst | arst;
  assign fire_req = frame & ~done & (cnt == '0) & (state == IDLE);
  assign slot_free = ~m_active;

  assign lfsr_col = (lfsr[3:0] >= 4'(INV_COLS)) ? lfsr[3:0] - 4'(INV_COLS) : lfsr[3:0];
  assign aim_off  = player_x - invaders_x;
  assign aim_div  = aim_off / 10'(COL_PITCH);
  assign aim_col  = (player_x < invaders_x)      ? 4'd0 :
                    (aim_div > 10'(INV_COLS - 1)) ? LAST_COL : aim_div[3:0];
  assign start_col = (AIM_MODE != 0) ? aim_col : lfsr_col;

  assign spawn_x = invaders_x + 10'(col) * 10'(COL_PITCH) + 10'(COL_PITCH/2 - 1);
  assign spawn_y = invaders_y + 10'(row) * 10'(ROW_PITCH) + 10'(SPRITE_H);

  invader_column_scan u_scan (
    .invaders   (invaders),
    .col        (col),
    .any_alive  (any_alive),
    .bottom_row (bottom_row)
  );

  always_comb begin
    spawn_oh = '0;
    for (int i = NUM_MISSILES - 1; i >= 0; i--)
      if (slot_free[i]) begin
        spawn_oh    = '0;
        spawn_oh[i] = 1'b1;
      end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr    <= LFSR_SEED;
      cnt     <= CNT_RELOAD;
      state   <= IDLE;
      col     <= '0;
      scanned <= '0;
      row     <= '0;
    end else begin
      lfsr    <= lfsr_next(lfsr);
      state   <= state_nxt;
      col     <= col_nxt;
      scanned <= scanned_nxt;
      row     <= row_nxt;
      if (frame && !done)
        cnt <= (cnt == '0) ? CNT_RELOAD : cnt - 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    col_nxt     = col;
    scanned_nxt = scanned;
    row_nxt     = row;
    spawn_en    = 1'b0;
    unique case (state)
      IDLE: if (fire_req && |slot_free) begin
        state_nxt   = SCAN;
        col_nxt     = start_col;
        scanned_nxt = '0;
      end
      SCAN: if (any_alive) begin
        state_nxt = SPAWN;
        row_nxt   = bottom_row;
      end else if (scanned == LAST_COL) begin
        state_nxt = IDLE;
      end else begin
        col_nxt     = (col == LAST_COL) ? 4'd0 : col + 4'd1;
        scanned_nxt = scanned + 4'd1;
      end
      SPAWN: begin
        spawn_en  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  for (genvar i = 0; i < NUM_MISSILES; i++) begin : g_slot
    logic        act_q;
    logic [9:0]  x_q, y_q;
    logic [10:0] y_sum;

    // 11-bit sum so a wrap past 1023 still counts as reaching the bottom.
    assign y_sum = {1'b0, y_q} + 11'(SPEED);

    always_ff @(posedge clk) begin
      if (reset) begin
        act_q <= 1'b0;
        x_q   <= '0;
        y_q   <= '0;
      end else if (spawn_en && spawn_oh[i]) begin
        act_q <= 1'b1;
        x_q   <= spawn_x;
        y_q   <= spawn_y;
      end else if (act_q && missile_collision[i]) begin
        act_q <= 1'b0;
        x_q   <= '0;
        y_q   <= '0;
      end else if (act_q && frame && !done) begin
        if (y_sum >= 11'(BOTTOM_Y)) begin
          act_q <= 1'b0;
          x_q   <= '0;
          y_q   <= '0;
        end else begin
          y_q <= y_sum[9:0];
        end
      end
    end

    assign m_active[i]       = act_q;
    assign m_x[10*i +: 10]   = x_q;
    assign m_y[10*i +: 10]   = y_q;
  end

endmodule

// File: tb/tb_missile_pool.sv
// Randomized scoreboard bench: a behavioural model predicts slot state and spawns
// for a random-column and an aimed instance; a negedge monitor pops and compares.
module tb_missile_pool;
  localparam int N   = 3;
  localparam int FI  = 2;
  localparam int SPD = 2;
  localparam int BOT = 470;
  localparam int W   = 10 * N;

  logic          clk = 1'b0;
  logic          rst = 1'b1, arst = 1'b0, frame = 1'b0, done = 1'b0;
  logic [54:0]   invaders = '1;
  logic [9:0]    inv_x = 10'd100, inv_y = 10'd50, player_x = 10'd200;
  logic [N-1:0]  coll = '0;
  logic [N-1:0]  act [2];
  logic [W-1:0]  xo [2];
  logic [W-1:0]  yo [2];

  always #5 clk = ~clk;

  missile_pool #(.NUM_MISSILES(N), .FIRE_INTERVAL(FI), .SPEED(SPD), .AIM_MODE(0),
                 .COL_PITCH(16), .ROW_PITCH(16), .SPRITE_H(8), .BOTTOM_Y(BOT)) dut0 (
    .clk(clk), .rst(rst), .arst(arst), .frame(frame), .done(done),
    .invaders(invaders), .invaders_x(inv_x), .invaders_y(inv_y), .player_x(player_x),
    .missile_collision(coll), .m_active(act[0]), .m_x(xo[0]), .m_y(yo[0]));

  missile_pool #(.NUM_MISSILES(N), .FIRE_INTERVAL(FI), .SPEED(SPD), .AIM_MODE(1),
                 .COL_PITCH(16), .ROW_PITCH(16), .SPRITE_H(8), .BOTTOM_Y(BOT)) dut1 (
    .clk(clk), .rst(rst), .arst(arst), .frame(frame), .done(done),
    .invaders(invaders), .invaders_x(inv_x), .invaders_y(inv_y), .player_x(player_x),
    .missile_collision(coll), .m_active(act[1]), .m_x(xo[1]), .m_y(yo[1]));

  typedef struct { int inst; int x; int y; int due; } spawn_t;
  typedef struct { int inst; logic [N-1:0] a; logic [W-1:0] x; logic [W-1:0] y; } snap_t;

  spawn_t spawn_q[$];
  snap_t  snap_q[$];
  int cyc = 0;
  int compared = 0;
  int mismatched = 0;

  // reference model state
  int lfsr;
  int cnt [2];
  int busy_end [2];
  bit pend [2];
  int pend_due [2];
  int pend_x [2];
  int pend_y [2];
  bit ma [2][N];
  int mx [2][N];
  int my [2][N];

  task automatic chk(input string nm, input int d, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s inst%0d @cyc %0d: got %0h, expected %0h", nm, d, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    lfsr = 16'hACE1;
    for (int d = 0; d < 2; d++) begin
      cnt[d] = FI - 1;
      busy_end[d] = -1;
      pend[d] = 1'b0;
      for (int i = 0; i < N; i++) begin
        ma[d][i] = 1'b0; mx[d][i] = 0; my[d][i] = 0;
      end
    end
    spawn_q.delete();
  endtask

  task automatic model_step(input int d);
    int slot, sc, c, row;
    bit found;
    slot = -1;
    for (int i = 0; i < N; i++) if (!ma[d][i] && slot < 0) slot = i;
    for (int i = 0; i < N; i++) begin
      if (coll[i] && ma[d][i]) begin
        ma[d][i] = 1'b0; mx[d][i] = 0; my[d][i] = 0;
      end else if (frame && !done && ma[d][i]) begin
        if (my[d][i] + SPD >= BOT) begin
          ma[d][i] = 1'b0; mx[d][i] = 0; my[d][i] = 0;
        end else my[d][i] = my[d][i] + SPD;
      end
    end
    if (pend[d] && cyc == pend_due[d] && slot >= 0) begin
      pend[d] = 1'b0;
      ma[d][slot] = 1'b1; mx[d][slot] = pend_x[d]; my[d][slot] = pend_y[d];
    end
    if (frame && !done) begin
      if (cnt[d] == 0) begin
        cnt[d] = FI - 1;
        if (cyc > busy_end[d] && slot >= 0) begin
          if (d == 0) begin
            sc = lfsr % 16;
            if (sc >= 11) sc = sc - 11;
          end else if (player_x < inv_x) sc = 0;
          else begin
            sc = (int'(player_x) - int'(inv_x)) / 16;
            if (sc > 10) sc = 10;
          end
          busy_end[d] = cyc + 11;
          found = 1'b0;
          for (int k = 0; k < 11; k++) begin
            c = (sc + k) % 11;
            row = -1;
            for (int r = 0; r < 5; r++) if (invaders[r*11 + c]) row = r;
            if (row >= 0 && !found) begin
              found = 1'b1;
              pend[d] = 1'b1;
              pend_due[d] = cyc + k + 2;
              pend_x[d] = (int'(inv_x) + c*16 + 7) % 1024;
              pend_y[d] = (int'(inv_y) + row*16 + 8) % 1024;
              busy_end[d] = pend_due[d];
              spawn_q.push_back('{d, pend_x[d], pend_y[d], pend_due[d]});
            end
          end
        end
      end else cnt[d] = cnt[d] - 1;
    end
  endtask

  // model: advances on every active edge using the inputs the DUT samples
  initial begin
    snap_t s;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst || arst) model_reset();
      else begin
        model_step(0);
        model_step(1);
        lfsr = ((lfsr << 1) | (((lfsr >> 15) ^ (lfsr >> 13) ^ (lfsr >> 12) ^ (lfsr >> 10)) & 1)) & 16'hFFFF;
      end
      for (int d = 0; d < 2; d++) begin
        s.inst = d;
        for (int i = 0; i < N; i++) begin
          s.a[i] = ma[d][i];
          s.x[10*i +: 10] = 10'(mx[d][i]);
          s.y[10*i +: 10] = 10'(my[d][i]);
        end
        snap_q.push_back(s);
      end
    end
  end

  // monitor
  initial begin
    snap_t s;
    logic [N-1:0] prev [2];
    logic [N-1:0] rise;
    int hit, d;
    prev[0] = '0; prev[1] = '0;
    forever begin
      @(negedge clk);
      while (snap_q.size() > 0) begin
        s = snap_q.pop_front();
        d = s.inst;
        chk("m_active", d, 32'(act[d]), 32'(s.a));
        chk("m_x", d, 32'(xo[d]), 32'(s.x));
        chk("m_y", d, 32'(yo[d]), 32'(s.y));
        rise = act[d] & ~prev[d];
        for (int i = 0; i < N; i++) if (rise[i]) begin
          hit = -1;
          for (int j = 0; j < spawn_q.size(); j++)
            if (hit < 0 && spawn_q[j].inst == d) hit = j;
          if (hit < 0) begin
            compared++; mismatched++;
            $display("FAIL spawn inst%0d @cyc %0d: got spawn in slot %0d, expected none", d, cyc, i);
          end else begin
            chk("spawn_x", d, 32'(xo[d][10*i +: 10]), 32'(spawn_q[hit].x));
            chk("spawn_y", d, 32'(yo[d][10*i +: 10]), 32'(spawn_q[hit].y));
            chk("spawn_cycle", d, 32'(cyc), 32'(spawn_q[hit].due));
            spawn_q.delete(hit);
          end
        end
        prev[d] = act[d];
      end
    end
  end

  // stimulus
  initial begin
    int per, sel, col;
    logic [63:0] t, t2;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int f = 0; f < 420; f++) begin
      per = $urandom_range(16, 24);
      for (int c = 0; c < per; c++) begin
        @(negedge clk);
        frame = (c == 0);
        rst = 1'b0;
        arst = 1'b0;
        coll = ($urandom_range(0, 39) == 0) ? N'($urandom()) : '0;
        // occasional reset a few cycles into a possible scan
        if (c == 3 && $urandom_range(0, 29) == 0) begin
          if ($urandom_range(0, 1) == 1) rst = 1'b1; else arst = 1'b1;
        end
        if (c == per - 1) begin
          sel = $urandom_range(0, 7);
          t  = {$urandom(), $urandom()};
          t2 = {$urandom(), $urandom()};
          case (sel)
            0: invaders = '0;
            1: invaders = '1;
            2, 3: begin
              invaders = '0;
              col = $urandom_range(0, 10);
              for (int r = 0; r < 5; r++) invaders[r*11 + col] = t[r];
              invaders[$urandom_range(0, 4)*11 + col] = 1'b1;
            end
            4: begin
              invaders = '1;
              for (int r = 0; r < 5; r++)
                for (int k = 3; k <= 5; k++) invaders[r*11 + k] = 1'b0;
            end
            5: invaders = t[54:0] & t2[54:0];
            default: invaders = t[54:0];
          endcase
          inv_x = 10'($urandom_range(0, 300));
          inv_y = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(380, 1023))
                                               : 10'($urandom_range(0, 250));
          player_x = 10'($urandom_range(0, 1023));
          done = ($urandom_range(0, 7) == 0);
        end
      end
    end
    @(negedge clk);
    frame = 1'b0; coll = '0; done = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    chk("spawn_outstanding", 0, 32'(spawn_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
